// File: rtl/set_mode_ctrl_if.sv
// Key/mode bus for set_mode_ctrl.
//   master : drives the raw active-low keys, observes mode/strobe/blink outputs
//   slave  : the controller; samples the keys, drives everything else
//   key_mode, key_sel, key_add : raw asynchronous keys, pressed = 0
//   mode                       : 0 NORMAL, 1 TIME_SET, 2 DATE_SET, 3 ALARM_SET
//   time/date/alarm_set_mod    : one-hot decode of mode, all 0 in NORMAL
//   sel_press, add_press       : one-cycle pulses for the active setter
//   commit_time, commit_date   : one-cycle load strobes on leaving TIME/DATE_SET
//   blink                      : selected-digit visible flag
interface set_mode_ctrl_if;
  logic       key_mode;
  logic       key_sel;
  logic       key_add;
  logic [1:0] mode;
  logic       time_set_mod;
  logic       date_set_mod;
  logic       alarm_set_mod;
  logic       sel_press;
  logic       add_press;
  logic       commit_time;
  logic       commit_date;
  logic       blink;

  modport master (
    output key_mode, key_sel, key_add,
    input  mode, time_set_mod, date_set_mod, alarm_set_mod,
    input  sel_press, add_press, commit_time, commit_date, blink
  );

  modport slave (
    input  key_mode, key_sel, key_add,
    output mode, time_set_mod, date_set_mod, alarm_set_mod,
    output sel_press, add_press, commit_time, commit_date, blink
  );
endinterface

// File: rtl/set_mode_ctrl.sv
// Clock set-mode controller: debounces three keys, steps the mode FSM
// NORMAL -> TIME_SET -> DATE_SET -> ALARM_SET -> NORMAL, forwards sel/add presses
// in set states, issues commit strobes and drives the digit blink flag.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : set_mode_ctrl_if.slave (keys in; mode, decodes, strobes, blink out)
// Optional: define SET_TIMEOUT_EN to abandon a set state to NORMAL (no commit)
// after T_TIMEOUT idle cycles.
module set_mode_ctrl #(
  parameter int unsigned T_DEBOUNCE = 500000,
  parameter int unsigned T_BLINK    = 12500000,
  parameter int unsigned T_TIMEOUT  = 500000000
) (
  input logic           clk,
  input logic           rst,
  set_mode_ctrl_if.slave bus
);

  localparam int unsigned DbW = (T_DEBOUNCE > 1) ? $clog2(T_DEBOUNCE) : 1;
  localparam int unsigned BlW = (T_BLINK > 1) ? $clog2(T_BLINK) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(T_DEBOUNCE - 1);
  localparam logic [BlW-1:0] BlMax = BlW'(T_BLINK - 1);

  typedef enum logic [1:0] {DbIdle, DbWait, DbRelease} db_state_e;
  typedef enum logic [1:0] {
    StNormal   = 2'd0,
    StTimeSet  = 2'd1,
    StDateSet  = 2'd2,
    StAlarmSet = 2'd3
  } mode_e;

  // Bit 0 mode, bit 1 sel, bit 2 add.
  logic [2:0] key_raw;
  logic [2:0] press;
  assign key_raw = {bus.key_add, bus.key_sel, bus.key_mode};

  for (genvar k = 0; k < 3; k++) begin : g_db
    logic [1:0]     sync_q;
    db_state_e      state_q, state_d;
    logic [DbW-1:0] cnt_q, cnt_d;
    logic           press_q, press_d;
    logic           key_s;

    assign key_s    = sync_q[1];
    assign press[k] = press_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= 2'b11;
        state_q <= DbIdle;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], key_raw[k]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      unique case (state_q)
        DbIdle: begin
          if (!key_s) begin
            state_d = DbWait;
            cnt_d   = '0;
          end
        end
        DbWait: begin
          // Early release re-arms without a pulse.
          if (key_s) begin
            state_d = DbIdle;
          end else if (cnt_q == DbMax) begin
            press_d = 1'b1;
            state_d = DbRelease;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DbRelease: begin
          // Needs an unbroken run of high samples before re-arming.
          if (!key_s) begin
            cnt_d = '0;
          end else if (cnt_q == DbMax) begin
            state_d = DbIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = DbIdle;
      endcase
    end
  end

  mode_e          mode_q, mode_d;
  logic           commit_time_q, commit_time_d;
  logic           commit_date_q, commit_date_d;
  logic           sel_press_q, sel_press_d;
  logic           add_press_q, add_press_d;
  logic           blink_q, blink_d;
  logic [BlW-1:0] blink_cnt_q, blink_cnt_d;
  logic           in_set, mode_chg, fwd, timeout_hit;

  assign in_set   = (mode_q != StNormal);
  assign mode_chg = (mode_d != mode_q);
  assign fwd      = sel_press_d | add_press_d;

`ifdef SET_TIMEOUT_EN
  localparam int unsigned ToW = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(T_TIMEOUT - 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = in_set && (to_cnt_q == ToMax);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!in_set || mode_chg || fwd) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToMax) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^T_TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    mode_d        = mode_q;
    commit_time_d = 1'b0;
    commit_date_d = 1'b0;
    if (press[0]) begin
      unique case (mode_q)
        StNormal:   mode_d = StTimeSet;
        StTimeSet:  begin mode_d = StDateSet;  commit_time_d = 1'b1; end
        StDateSet:  begin mode_d = StAlarmSet; commit_date_d = 1'b1; end
        StAlarmSet: mode_d = StNormal;
        default:    mode_d = StNormal;
      endcase
    end else if (timeout_hit) begin
      mode_d = StNormal;
    end
    // A coincident mode press wins; sel/add in NORMAL are dropped.
    sel_press_d = press[1] & in_set & ~press[0];
    add_press_d = press[2] & in_set & ~press[0];
  end

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (mode_d == StNormal || mode_chg || fwd) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BlMax) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= StNormal;
      commit_time_q <= 1'b0;
      commit_date_q <= 1'b0;
      sel_press_q   <= 1'b0;
      add_press_q   <= 1'b0;
      blink_q       <= 1'b1;
      blink_cnt_q   <= '0;
    end else begin
      mode_q        <= mode_d;
      commit_time_q <= commit_time_d;
      commit_date_q <= commit_date_d;
      sel_press_q   <= sel_press_d;
      add_press_q   <= add_press_d;
      blink_q       <= blink_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  always_comb begin
    bus.time_set_mod  = 1'b0;
    bus.date_set_mod  = 1'b0;
    bus.alarm_set_mod = 1'b0;
    unique case (mode_q)
      StTimeSet:  bus.time_set_mod  = 1'b1;
      StDateSet:  bus.date_set_mod  = 1'b1;
      StAlarmSet: bus.alarm_set_mod = 1'b1;
      default:    ;
    endcase
  end

  assign bus.mode        = mode_q;
  assign bus.sel_press   = sel_press_q;
  assign bus.add_press   = add_press_q;
  assign bus.commit_time = commit_time_q;
  assign bus.commit_date = commit_date_q;
  assign bus.blink       = blink_q;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl with T_DEBOUNCE=4, T_BLINK=8, T_TIMEOUT=64.
// A monitor pops an expected event whenever mode changes or a strobe fires.
module tb_set_mode_ctrl;
  localparam int unsigned TDb = 4;
  localparam int unsigned TBl = 8;
  localparam int unsigned TTo = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_mode_ctrl_if bus ();

  set_mode_ctrl #(
    .T_DEBOUNCE(TDb),
    .T_BLINK   (TBl),
    .T_TIMEOUT (TTo)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic       ct;
    logic       cd;
    logic       sp;
    logic       ap;
  } ev_t;

  typedef struct {
    int  key;
    int  hold;
    bit  has_ev;
    ev_t exp;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   cur_mode = 0;

  function automatic ev_t mk_ev(int m, bit ct, bit cd, bit sp, bit ap);
    ev_t e;
    e.mode = 2'(m);
    e.ct = ct; e.cd = cd; e.sp = sp; e.ap = ap;
    return e;
  endfunction

  function automatic vec_t mk_vec(int key, int hold, bit has, int m, bit ct, bit cd,
                                  bit sp, bit ap);
    vec_t v;
    v.key = key; v.hold = hold; v.has_ev = has;
    v.exp = mk_ev(m, ct, cd, sp, ap);
    return v;
  endfunction

  function automatic ev_t sample();
    ev_t e;
    e.mode = bus.mode;
    e.ct = bus.commit_time; e.cd = bus.commit_date;
    e.sp = bus.sel_press;   e.ap = bus.add_press;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic set_key(int key, logic v);
    case (key)
      0:       bus.key_mode = v;
      1:       bus.key_sel  = v;
      default: bus.key_add  = v;
    endcase
  endtask

  task automatic press(int key, int hold);
    set_key(key, 1'b0);
    repeat (hold) @(negedge clk);
    set_key(key, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    chk({name, " pending_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic mode_step();
    ev_t e;
    e = mk_ev((cur_mode + 1) % 4, cur_mode == 1, cur_mode == 2, 1'b0, 1'b0);
    exp_q.push_back(e);
    press(0, 10);
    drain("mode_step");
    cur_mode = int'(e.mode);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, " mode"},          int'(bus.mode), 0);
    chk({tag, " time_set_mod"},  int'(bus.time_set_mod), 0);
    chk({tag, " date_set_mod"},  int'(bus.date_set_mod), 0);
    chk({tag, " alarm_set_mod"}, int'(bus.alarm_set_mod), 0);
    chk({tag, " sel_press"},     int'(bus.sel_press), 0);
    chk({tag, " add_press"},     int'(bus.add_press), 0);
    chk({tag, " commit_time"},   int'(bus.commit_time), 0);
    chk({tag, " commit_date"},   int'(bus.commit_date), 0);
    chk({tag, " blink"},         int'(bus.blink), 1);
  endtask

  initial begin
    bit found;
    bit saw;

    // key, hold, event?, then mode after the vector and the event strobes
    vecs.push_back(mk_vec(0,  2, 0, 0, 0, 0, 0, 0)); // glitch: no press
    vecs.push_back(mk_vec(1, 10, 0, 0, 0, 0, 0, 0)); // sel in NORMAL dropped
    vecs.push_back(mk_vec(0, 10, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk_vec(1, 10, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk_vec(2, 10, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk_vec(0,  3, 0, 1, 0, 0, 0, 0)); // too short
    vecs.push_back(mk_vec(0, 10, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk_vec(1, 10, 1, 2, 0, 0, 1, 0));
    vecs.push_back(mk_vec(0, 10, 1, 3, 0, 1, 0, 0));
    vecs.push_back(mk_vec(2, 10, 1, 3, 0, 0, 0, 1));
    vecs.push_back(mk_vec(0, 30, 1, 0, 0, 0, 0, 0)); // long hold, one step
    vecs.push_back(mk_vec(2, 10, 0, 0, 0, 0, 0, 0)); // add in NORMAL dropped
    vecs.push_back(mk_vec(0, 10, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk_vec(0, 10, 1, 2, 1, 0, 0, 0));

    fork
      begin : monitor
        ev_t cur;
        ev_t e;
        logic [1:0] prev_mode;
        prev_mode = 2'd0;
        forever begin
          @(negedge clk);
          cur = sample();
          if (mon_en && (cur.mode != prev_mode || cur.ct || cur.cd || cur.sp || cur.ap)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_event: got mode=%0d ct=%0b cd=%0b sel=%0b add=%0b, required none",
                       cur.mode, cur.ct, cur.cd, cur.sp, cur.ap);
            end else begin
              e = exp_q.pop_front();
              if (cur !== e) begin
                n_fail++;
                $display("FAIL event: got mode=%0d ct=%0b cd=%0b sel=%0b add=%0b, required mode=%0d ct=%0b cd=%0b sel=%0b add=%0b",
                         cur.mode, cur.ct, cur.cd, cur.sp, cur.ap,
                         e.mode, e.ct, e.cd, e.sp, e.ap);
              end
            end
          end
          prev_mode = cur.mode;
        end
      end
    join_none

    rst = 1'b1;
    bus.key_mode = 1'b1;
    bus.key_sel  = 1'b1;
    bus.key_add  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].has_ev) exp_q.push_back(vecs[i].exp);
      press(vecs[i].key, vecs[i].hold);
      if (vecs[i].has_ev) drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d mode", i), int'(bus.mode), int'(vecs[i].exp.mode));
    end
    cur_mode = 2;

    // DATE_SET: one add press, then blink restarts high and toggles every 8.
    exp_q.push_back(mk_ev(2, 0, 0, 0, 1));
    set_key(2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.add_press) found = 1'b1;
    end
    chk("add_press seen", int'(found), 1);
    if (found) begin
      for (int k = 0; k < 24; k++) begin
        chk($sformatf("blink k=%0d", k), int'(bus.blink), int'((k / 8) % 2 == 0));
        if (k == 2) set_key(2, 1'b1);
        @(negedge clk);
      end
    end
    set_key(2, 1'b1);
    repeat (12) @(negedge clk);
    drain("blink");

    // Coincident mode+add in TIME_SET: mode step wins, add dropped.
    while (cur_mode != 1) mode_step();
    exp_q.push_back(mk_ev(2, 1, 0, 0, 0));
    bus.key_mode = 1'b0;
    bus.key_add  = 1'b0;
    repeat (10) @(negedge clk);
    bus.key_mode = 1'b1;
    bus.key_add  = 1'b1;
    repeat (12) @(negedge clk);
    drain("coincident");
    chk("coincident mode", int'(bus.mode), 2);
    cur_mode = 2;

    // Idle in TIME_SET.
    while (cur_mode != 1) mode_step();
`ifdef SET_TIMEOUT_EN
    exp_q.push_back(mk_ev(0, 0, 0, 0, 0));
`endif
    repeat (80) @(negedge clk);
`ifdef SET_TIMEOUT_EN
    chk("timeout mode", int'(bus.mode), 0);
    cur_mode = 0;
`else
    chk("no_timeout mode", int'(bus.mode), 1);
`endif
    drain("timeout");

    // Reset during a DATE_SET debounce wait.
    while (cur_mode != 2) mode_step();
    mon_en = 1'b0;
    set_key(0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    set_key(0, 1'b1);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.commit_date || bus.commit_time || bus.sel_press || bus.add_press ||
          bus.mode != 2'd0) saw = 1'b1;
    end
    chk("post_reset quiet", int'(saw), 0);
    chk("final pending_events", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
